llc_flush_sequencer: RTL and testbench

Sequences whole-cache reset/flush operations for the Spandex LLC. It accepts one reset/flush command from the testbench/host interface and walks every (set, way) pair in order. For each pair it issues one line operation to the LLC main FSM through a grant-gated handshake, then waits for completion. It owns the `ongoing_flush`/`flush_set`/`flush_way` state that the LLC input decoder consults for priority, and it returns a done handshake when the walk finishes.

---
 rtl/llc_flush_sequencer_pkg.sv | 18 +
 rtl/llc_flush_counter.sv | 45 ++++
 rtl/llc_flush_sequencer.sv | 108 ++++++++++
 tb/tb_llc_flush_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/llc_flush_sequencer_pkg.sv
// Shared LLC geometry, index types and flush sequencer state encoding.
package llc_flush_sequencer_pkg;

  localparam int LLC_SETS = 256;
  localparam int LLC_WAYS = 16;

  typedef logic [$clog2(LLC_SETS)-1:0] llc_set_t;
  typedef logic [$clog2(LLC_WAYS)-1:0] llc_way_t;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_DRAIN,
    FS_ISSUE,
    FS_WAIT,
    FS_DONE
  } llc_flush_state_t;

endpackage

// File: rtl/llc_flush_counter.sv
// Set-major / way-minor (set, way) walk counter with clear, advance and a
// flag marking the last pair of the walk.
module llc_flush_counter
  import llc_flush_sequencer_pkg::*;
#(
  parameter int SETS  = LLC_SETS,
  parameter int WAYS  = LLC_WAYS,
  parameter int SET_W = $clog2(SETS) + 1,
  parameter int WAY_W = $clog2(WAYS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [SET_W-1:0] set_cnt,
  output logic [WAY_W-1:0] way_cnt,
  output logic             last_pair
);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETS - 1);
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(WAYS - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [WAY_W-1:0] WAY_ONE  = WAY_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_cnt <= '0;
      way_cnt <= '0;
    end else if (clr) begin
      set_cnt <= '0;
      way_cnt <= '0;
    end else if (adv) begin
      if (way_cnt == WAY_LAST) begin
        way_cnt <= '0;
        set_cnt <= set_cnt + SET_ONE;
      end else begin
        way_cnt <= way_cnt + WAY_ONE;
      end
    end
  end

  // Advancing from this pair lands the set counter on its terminal value SETS.
  assign last_pair = (set_cnt == SET_LAST) && (way_cnt == WAY_LAST);

endmodule

// File: rtl/llc_flush_sequencer.sv
// Walks every (set, way) of the LLC for one reset/flush command, issuing one
// grant-gated line op per pair and returning a done handshake at the end.
module llc_flush_sequencer
  import llc_flush_sequencer_pkg::*;
#(
  parameter int SETS  = LLC_SETS,
  parameter int WAYS  = LLC_WAYS,
  parameter int SET_W = $clog2(SETS) + 1,
  parameter int WAY_W = $clog2(WAYS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_tb_valid,
  input  logic             rst_tb_mode,
  output logic             rst_tb_ready,
  input  logic             mshr_idle,
  input  logic             grant,
  output logic             op_valid,
  output logic [SET_W-2:0] op_set,
  output logic [WAY_W-2:0] op_way,
  output logic             op_wb,
  input  logic             op_done,
  output logic             ongoing_flush,
  output logic [SET_W-1:0] flush_set,
  output logic [WAY_W-1:0] flush_way,
  output logic             rst_tb_done_valid,
  input  logic             rst_tb_done_ready
);

  llc_flush_state_t state_q, state_d;
  logic mode_q;
  logic cnt_clr, cnt_adv, last_pair, accept, done_hs;

  llc_flush_counter #(
    .SETS (SETS),
    .WAYS (WAYS),
    .SET_W(SET_W),
    .WAY_W(WAY_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .set_cnt  (flush_set),
    .way_cnt  (flush_way),
    .last_pair(last_pair)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FS_IDLE;
      mode_q        <= 1'b0;
      ongoing_flush <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q        <= rst_tb_mode;
        ongoing_flush <= 1'b1;
      end else if (done_hs) begin
        mode_q        <= 1'b0;
        ongoing_flush <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_tb_ready = 1'b0;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;
    accept       = 1'b0;
    done_hs      = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        rst_tb_ready = rst_tb_valid;
        if (rst_tb_valid) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: if (mshr_idle) state_d = FS_ISSUE;
      FS_ISSUE: if (grant) state_d = FS_WAIT;
      FS_WAIT: begin
        if (op_done) begin
          cnt_adv = 1'b1;
          state_d = last_pair ? FS_DONE : FS_ISSUE;
        end
      end
      FS_DONE: begin
        if (rst_tb_done_ready) begin
          done_hs = 1'b1;
          cnt_clr = 1'b1;
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // Everything below depends only on registered state, never on grant/op_done.
  assign op_valid          = (state_q == FS_ISSUE);
  assign op_set            = flush_set[SET_W-2:0];
  assign op_way            = flush_way[WAY_W-2:0];
  assign op_wb             = mode_q;
  assign rst_tb_done_valid = (state_q == FS_DONE);

endmodule

// File: tb/tb_llc_flush_sequencer.sv
// Directed bench for llc_flush_sequencer (4 sets x 2 ways) with an op scoreboard.
module tb_llc_flush_sequencer;

  localparam int SETS  = 4;
  localparam int WAYS  = 2;
  localparam int SET_W = 3;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             rst_tb_valid, rst_tb_mode, rst_tb_ready;
  logic             mshr_idle, grant, op_valid, op_wb, op_done;
  logic [SET_W-2:0] op_set;
  logic [WAY_W-2:0] op_way;
  logic             ongoing_flush;
  logic [SET_W-1:0] flush_set;
  logic [WAY_W-1:0] flush_way;
  logic             rst_tb_done_valid, rst_tb_done_ready;

  typedef struct packed {
    logic [1:0] s;
    logic       w;
    logic       wb;
  } op_t;

  op_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  llc_flush_sequencer #(
    .SETS(SETS), .WAYS(WAYS), .SET_W(SET_W), .WAY_W(WAY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rst_tb_valid(rst_tb_valid), .rst_tb_mode(rst_tb_mode), .rst_tb_ready(rst_tb_ready),
    .mshr_idle(mshr_idle), .grant(grant),
    .op_valid(op_valid), .op_set(op_set), .op_way(op_way), .op_wb(op_wb),
    .op_done(op_done), .ongoing_flush(ongoing_flush),
    .flush_set(flush_set), .flush_way(flush_way),
    .rst_tb_done_valid(rst_tb_done_valid), .rst_tb_done_ready(rst_tb_done_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_walk(input logic wb);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        exp_q.push_back('{s: 2'(s), w: 1'(w), wb: wb});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op_valid"}, op_valid, 0);
    chk({tag, "_op_wb"}, op_wb, 0);
    chk({tag, "_op_addr"}, {op_set, op_way}, 0);
    chk({tag, "_ongoing"}, ongoing_flush, 0);
    chk({tag, "_flush_set"}, flush_set, 0);
    chk({tag, "_flush_way"}, flush_way, 0);
    chk({tag, "_done_valid"}, rst_tb_done_valid, 0);
  endtask

  // Waits (bounded) for a presented op, checks it against the scoreboard,
  // then fires it; with fire_done the op is completed one cycle later.
  task automatic do_op(input bit stall, input bit cmd_pending, input bit fire_done);
    op_t e;
    int  n = 0;
    while (!op_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("op_valid_rise", op_valid, 1);
    chk("sb_nonempty", exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("op_set", op_set, e.s);
    chk("op_way", op_way, e.w);
    chk("op_wb", op_wb, e.wb);
    chk("flush_set", flush_set, {1'b0, e.s});
    chk("flush_way", flush_way, {1'b0, e.w});
    if (cmd_pending) chk("ready_busy", rst_tb_ready, 0);
    if (stall) begin
      op_done = 1'b1;
      @(negedge clk);
      op_done = 1'b0;
      for (int k = 0; k < 2; k++) begin
        chk("stall_valid", op_valid, 1);
        chk("stall_addr", {op_set, op_way}, {e.s, e.w});
        chk("stray_done_way", flush_way, {1'b0, e.w});
        @(negedge clk);
      end
      chk("stall_valid_end", op_valid, 1);
    end
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    chk("wait_no_valid", op_valid, 0);
    if (fire_done) begin
      op_done = 1'b1;
      @(negedge clk);
      op_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rst_tb_valid = 1'b0; rst_tb_mode = 1'b0; mshr_idle = 1'b0;
    grant = 1'b0; op_done = 1'b0; rst_tb_done_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_ready", rst_tb_ready, 0);
    rst = 1'b1;
    @(negedge clk);

    // Walk A: flush mode, MSHRs busy for 5 cycles, a second command held pending.
    rst_tb_mode = 1'b1;
    rst_tb_valid = 1'b1;
    #1 chk("idle_ready", rst_tb_ready, 1);
    push_walk(1'b1);
    @(negedge clk);
    rst_tb_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("drain_no_op", op_valid, 0);
      chk("drain_ongoing", ongoing_flush, 1);
      chk("drain_ready", rst_tb_ready, 0);
      @(negedge clk);
    end
    mshr_idle = 1'b1;
    @(negedge clk);
    chk("first_op_after_idle", op_valid, 1);
    for (int i = 0; i < SETS * WAYS; i++) do_op(i == 2, 1'b1, 1'b1);
    chk("sb_drained", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      chk("done_valid_hold", rst_tb_done_valid, 1);
      chk("done_set", flush_set, SETS);
      chk("done_way", flush_way, 0);
      chk("done_ongoing", ongoing_flush, 1);
      chk("done_ready_busy", rst_tb_ready, 0);
      @(negedge clk);
    end
    rst_tb_done_ready = 1'b1;
    #1 chk("done_hs_ready", rst_tb_ready, 0);
    @(negedge clk);
    rst_tb_done_ready = 1'b0;
    chk("cleared_done", rst_tb_done_valid, 0);
    chk("cleared_ongoing", ongoing_flush, 0);
    chk("cleared_set", flush_set, 0);
    chk("cleared_way", flush_way, 0);
    chk("cleared_wb", op_wb, 0);
    chk("pending_accept", rst_tb_ready, 1);

    // Walk B: reset mode, accepted from the pending command, then aborted at (2,1).
    push_walk(1'b0);
    @(negedge clk);
    rst_tb_valid = 1'b0;
    chk("accept_plus1", op_valid, 0);
    @(negedge clk);
    chk("accept_plus2", op_valid, 1);
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b0, 1'b1);
    do_op(1'b0, 1'b0, 1'b0);
    chk("abort_at_set", flush_set, 2);
    chk("abort_at_way", flush_way, 1);
    rst = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_abort_done", rst_tb_done_valid, 0);
      chk("post_abort_op", op_valid, 0);
      chk("post_abort_ongoing", ongoing_flush, 0);
    end

    // Walk C: fresh flush command restarts from (0,0) and completes.
    rst_tb_mode = 1'b1;
    rst_tb_valid = 1'b1;
    push_walk(1'b1);
    @(negedge clk);
    rst_tb_valid = 1'b0;
    for (int i = 0; i < SETS * WAYS; i++) do_op(1'b0, 1'b0, 1'b1);
    chk("c_done_valid", rst_tb_done_valid, 1);
    rst_tb_done_ready = 1'b1;
    @(negedge clk);
    rst_tb_done_ready = 1'b0;
    chk("c_done_clear", rst_tb_done_valid, 0);
    chk("c_ongoing_clear", ongoing_flush, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
